if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the CPU decode stage.
- Owns the fetch PC and drives a synchronous-read instruction memory (1-cycle read latency, word-indexed by imem_addr[8:2]).
- Presents instructions to decode through a valid/ready handshake, with a 1-entry skid buffer so back-pressure never loses an in-flight read.
- Handles PC redirects (branch/jump/trap) from downstream, squashing all wrong-path work.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/if_fetch_unit_if.sv | 42 ++++
 rtl/ifu_skid_buf.sv | 38 +++
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and the fetch entry record for the instruction-fetch unit.
package ifu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory, redirect and decode-handshake bundle of the fetch unit.
// id_fault exists only when IF_MISALIGN_TRAP_EN is defined.
interface if_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc4;
`ifdef IF_MISALIGN_TRAP_EN
    logic            id_fault;
`endif

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        input  id_ready,
`ifdef IF_MISALIGN_TRAP_EN
        output id_fault,
`endif
        output id_valid, id_instr, id_pc, id_pc4
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        output id_ready,
`ifdef IF_MISALIGN_TRAP_EN
        input  id_fault,
`endif
        input  id_valid, id_instr, id_pc, id_pc4
    );

endinterface

// File: rtl/ifu_skid_buf.sv
// One-entry holding register catching a read response while decode stalls.
module ifu_skid_buf
    import ifu_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_unload,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);

    logic         r_valid_p1;
    fetch_entry_t r_entry_p1;

    // Load wins over unload so a same-cycle refill keeps the slot occupied.
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_valid_p1 <= 1'b0;
        end else if (i_load) begin
            r_valid_p1 <= 1'b1;
        end else if (i_unload) begin
            r_valid_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_entry_p1 <= i_entry;
        end
    end

    assign o_valid = r_valid_p1;
    assign o_entry = r_entry_p1;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle imem reads and feeds decode via valid/ready.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = ifu_pkg::DEFAULT_RESET_PC
) (
    input logic             clk,
    input logic             rstn,
    if_fetch_unit_if.master ifu
);
    import ifu_pkg::*;

    logic [XLEN-1:0] r_pc_f;
    logic            r_inflight_p1;
    logic [XLEN-1:0] r_inflight_pc_p1;
    logic            r_id_vld_p2;
    fetch_entry_t    r_id_p2;

    fetch_entry_t    w_resp;
    fetch_entry_t    w_skid_q;
    logic            w_skid_vld;
    logic            w_deq;
    logic            w_out_free;
    logic            w_resp_vld;
    logic            w_skid_load;
    logic            w_skid_unload;
    logic            w_issue;
    logic            w_halt;
    logic [1:0]      w_occ;

`ifdef IF_MISALIGN_TRAP_EN
    logic            r_halt;
    logic            r_trap_pend;
    logic [XLEN-1:0] r_trap_pc;
    assign w_halt       = r_halt;
    assign ifu.id_fault = r_id_p2.fault;
`else
    logic            w_unused;
    assign w_halt   = 1'b0;
    assign w_unused = r_id_p2.fault | (|ifu.redirect_pc[1:0]);
`endif

    // Issue only while the output, skid and in-flight slots can absorb the result.
    assign w_occ      = 2'(r_id_vld_p2) + 2'(w_skid_vld) + 2'(r_inflight_p1);
    assign w_deq      = r_id_vld_p2 & ifu.id_ready;
    assign w_issue    = rstn & ~ifu.redirect_valid & ((w_occ - 2'(w_deq)) < 2'd2) & ~w_halt;
    assign w_out_free = ~r_id_vld_p2 | w_deq;
    assign w_resp_vld = r_inflight_p1 & ~ifu.redirect_valid;
    assign w_resp     = '{instr: ifu.imem_rdata, pc: r_inflight_pc_p1, fault: 1'b0};

    assign w_skid_unload = w_out_free & w_skid_vld & ~ifu.redirect_valid;
    assign w_skid_load   = w_resp_vld & ~(w_out_free & ~w_skid_vld);

    assign ifu.imem_en   = w_issue;
    assign ifu.imem_addr = r_pc_f;

    // Stage p0 -> p1: PC register and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc_f        <= RESET_PC;
            r_inflight_p1 <= 1'b0;
        end else if (ifu.redirect_valid) begin
            r_pc_f        <= {ifu.redirect_pc[XLEN-1:2], 2'b00};
            r_inflight_p1 <= 1'b0;
        end else begin
            r_inflight_p1 <= w_issue;
            if (w_issue) begin
                r_pc_f <= r_pc_f + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_inflight_pc_p1 <= r_pc_f;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_halt      <= 1'b0;
            r_trap_pend <= 1'b0;
        end else if (ifu.redirect_valid) begin
            r_halt      <= |ifu.redirect_pc[1:0];
            r_trap_pend <= |ifu.redirect_pc[1:0];
            r_trap_pc   <= ifu.redirect_pc;
        end else begin
            r_trap_pend <= 1'b0;
        end
    end
`endif

    ifu_skid_buf u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .i_flush  (ifu.redirect_valid),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_entry  (w_resp),
        .o_valid  (w_skid_vld),
        .o_entry  (w_skid_q)
    );

    // Stage p1 -> p2: decode-facing output register; skid has priority over a fresh response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_id_vld_p2 <= 1'b0;
            r_id_p2     <= '{instr: NOP_INSTR, pc: '0, fault: 1'b0};
        end else if (ifu.redirect_valid) begin
            r_id_vld_p2 <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        end else if (r_trap_pend) begin
            r_id_vld_p2 <= 1'b1;
            r_id_p2     <= '{instr: NOP_INSTR, pc: r_trap_pc, fault: 1'b1};
`endif
        end else if (w_out_free) begin
            if (w_skid_vld) begin
                r_id_vld_p2 <= 1'b1;
                r_id_p2     <= w_skid_q;
            end else if (w_resp_vld) begin
                r_id_vld_p2 <= 1'b1;
                r_id_p2     <= w_resp;
            end else begin
                r_id_vld_p2 <= 1'b0;
            end
        end
    end

    assign ifu.id_valid = r_id_vld_p2;
    assign ifu.id_instr = r_id_p2.instr;
    assign ifu.id_pc    = r_id_p2.pc;
    assign ifu.id_pc4   = r_id_p2.pc + XLEN'(4);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle table, hand sequences and a randomized stream-order model.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bus2 ();

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ifu  (bus)
    );

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk  (clk),
        .rstn (rstn),
        .ifu  (bus2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h100 + {25'd0, addr[8:2]};
    endfunction

    always @(posedge clk) begin
        if (bus.imem_en)  bus.imem_rdata  <= mem_word(bus.imem_addr);
        if (bus2.imem_en) bus2.imem_rdata <= mem_word(bus2.imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic en, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        bus2.id_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
    end

    initial begin
        logic [31:0] exp_issue;
        logic [31:0] exp_deliv;
        logic        prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic [31:0] tgt;
        int          accepts;

        // Streaming fill, 5-cycle stall, stall with skid full then redirect to 0x40.
        tbl[0]  = mk(1, 0, 0,     1, 32'h00, 0, 0);
        tbl[1]  = mk(1, 0, 0,     1, 32'h04, 0, 0);
        tbl[2]  = mk(1, 0, 0,     1, 32'h08, 1, 32'h00);
        tbl[3]  = mk(1, 0, 0,     1, 32'h0C, 1, 32'h04);
        tbl[4]  = mk(1, 0, 0,     1, 32'h10, 1, 32'h08);
        tbl[5]  = mk(1, 0, 0,     1, 32'h14, 1, 32'h0C);
        tbl[6]  = mk(0, 0, 0,     0, 0,      1, 32'h10);
        tbl[7]  = mk(0, 0, 0,     0, 0,      1, 32'h10);
        tbl[8]  = mk(0, 0, 0,     0, 0,      1, 32'h10);
        tbl[9]  = mk(0, 0, 0,     0, 0,      1, 32'h10);
        tbl[10] = mk(0, 0, 0,     0, 0,      1, 32'h10);
        tbl[11] = mk(1, 0, 0,     1, 32'h18, 1, 32'h10);
        tbl[12] = mk(1, 0, 0,     1, 32'h1C, 1, 32'h14);
        tbl[13] = mk(1, 0, 0,     1, 32'h20, 1, 32'h18);
        tbl[14] = mk(0, 0, 0,     0, 0,      1, 32'h1C);
        tbl[15] = mk(0, 1, 32'h40, 0, 0,     1, 32'h1C);
        tbl[16] = mk(1, 0, 0,     1, 32'h40, 0, 0);
        tbl[17] = mk(1, 0, 0,     1, 32'h44, 0, 0);
        tbl[18] = mk(1, 0, 0,     1, 32'h48, 1, 32'h40);
        tbl[19] = mk(1, 0, 0,     1, 32'h4C, 1, 32'h44);

        rstn               = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        sample();
        chk("rst_en", 32'(bus.imem_en), 0);
        chk("rst_vld", 32'(bus.id_valid), 0);
        chk("rst_instr", bus.id_instr, ifu_pkg::NOP_INSTR);
        chk("rst_pc", bus.id_pc, 0);
        chk("rst_pc4", bus.id_pc4, 4);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int c = 0; c < 20; c++) begin
            if (c != 0) step();
            bus.id_ready       = tbl[c].rdy;
            bus.redirect_valid = tbl[c].rv;
            bus.redirect_pc    = tbl[c].rpc;
            sample();
            chk($sformatf("tbl%0d_en", c), 32'(bus.imem_en), 32'(tbl[c].en));
            if (tbl[c].en) chk($sformatf("tbl%0d_addr", c), bus.imem_addr, tbl[c].addr);
            chk($sformatf("tbl%0d_vld", c), 32'(bus.id_valid), 32'(tbl[c].vld));
            if (tbl[c].vld) begin
                chk($sformatf("tbl%0d_pc", c), bus.id_pc, tbl[c].pc);
                chk($sformatf("tbl%0d_instr", c), bus.id_instr, mem_word(tbl[c].pc));
                chk($sformatf("tbl%0d_pc4", c), bus.id_pc4, tbl[c].pc + 32'd4);
            end
            if (c == 0) chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
            if (c == 1) chk("wrap_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
            if (c == 2) chk("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
            if (c == 3) begin
                chk("wrap_vld", 32'(bus2.id_valid), 1);
                chk("wrap_pc", bus2.id_pc, 32'hFFFF_FFFC);
                chk("wrap_pc4", bus2.id_pc4, 32'h0);
            end
        end

        // Mid-stream reset with the output and skid slots occupied.
        step(); bus.id_ready = 1'b0; sample();
        step(); rstn = 1'b0; sample();
        chk("mrst_en_low", 32'(bus.imem_en), 0);
        step(); sample();
        chk("mrst_vld", 32'(bus.id_valid), 0);
        chk("mrst_instr", bus.id_instr, ifu_pkg::NOP_INSTR);
        chk("mrst_pc", bus.id_pc, 0);
        chk("mrst_pc4", bus.id_pc4, 4);
        step(); rstn = 1'b1; bus.id_ready = 1'b1; sample();
        chk("mrst_restart_en", 32'(bus.imem_en), 1);
        chk("mrst_restart_addr", bus.imem_addr, 0);
        chk("mrst_restart_vld", 32'(bus.id_valid), 0);
        step(); sample();
        chk("mrst_addr4", bus.imem_addr, 4);
        chk("mrst_vld1", 32'(bus.id_valid), 0);
        step(); sample();
        chk("mrst_first_vld", 32'(bus.id_valid), 1);
        chk("mrst_first_pc", bus.id_pc, 0);
        chk("mrst_first_instr", bus.id_instr, 32'h100);

        // Misaligned redirect target.
        step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h22; sample();
        chk("mis_en_redir", 32'(bus.imem_en), 0);
        step(); bus.redirect_valid = 1'b0; sample();
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_en_idle", 32'(bus.imem_en), 0);
        chk("mis_vld0", 32'(bus.id_valid), 0);
        step(); bus.id_ready = 1'b0; sample();
        chk("mis_fault_vld", 32'(bus.id_valid), 1);
        chk("mis_fault", 32'(bus.id_fault), 1);
        chk("mis_fault_pc", bus.id_pc, 32'h22);
        chk("mis_fault_instr", bus.id_instr, ifu_pkg::NOP_INSTR);
        chk("mis_fault_en", 32'(bus.imem_en), 0);
        step(); sample();
        chk("mis_hold_vld", 32'(bus.id_valid), 1);
        chk("mis_hold_pc", bus.id_pc, 32'h22);
        step(); bus.id_ready = 1'b1; sample();
        chk("mis_acc_vld", 32'(bus.id_valid), 1);
        step(); sample();
        chk("mis_after_vld", 32'(bus.id_valid), 0);
        chk("mis_after_en", 32'(bus.imem_en), 0);
        step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80; sample();
        step(); bus.redirect_valid = 1'b0; sample();
        chk("mis_resume_en", 32'(bus.imem_en), 1);
        chk("mis_resume_addr", bus.imem_addr, 32'h80);
        step(); sample();
        step(); sample();
        chk("mis_resume_vld", 32'(bus.id_valid), 1);
        chk("mis_resume_pc", bus.id_pc, 32'h80);
        chk("mis_resume_fault", 32'(bus.id_fault), 0);
`else
        chk("mis_en", 32'(bus.imem_en), 1);
        chk("mis_addr", bus.imem_addr, 32'h20);
        chk("mis_vld0", 32'(bus.id_valid), 0);
        step(); sample();
        step(); sample();
        chk("mis_vld", 32'(bus.id_valid), 1);
        chk("mis_pc", bus.id_pc, 32'h20);
        chk("mis_instr", bus.id_instr, 32'h108);
`endif

        // Randomized traffic against an in-order stream model.
        exp_issue  = 0;
        exp_deliv  = 0;
        prev_hold  = 1'b0;
        prev_pc    = 0;
        prev_instr = 0;
        accepts    = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            bus.id_ready = ($urandom % 10) < 7;
            if (i == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h100;
            end else begin
                bus.redirect_valid = ($urandom % 20) == 0;
                bus.redirect_pc    = 32'($urandom_range(0, 255)) << 2;
            end
            sample();
            if (prev_hold) begin
                chk("rnd_hold_vld", 32'(bus.id_valid), 1);
                chk("rnd_hold_pc", bus.id_pc, prev_pc);
                chk("rnd_hold_instr", bus.id_instr, prev_instr);
            end
            if (bus.redirect_valid) begin
                chk("rnd_redir_en", 32'(bus.imem_en), 0);
                tgt       = {bus.redirect_pc[31:2], 2'b00};
                exp_issue = tgt;
                exp_deliv = tgt;
            end else begin
                if (bus.imem_en) begin
                    chk("rnd_issue_addr", bus.imem_addr, exp_issue);
                    exp_issue = exp_issue + 32'd4;
                end
                if (bus.id_valid && bus.id_ready) begin
                    chk("rnd_deq_pc", bus.id_pc, exp_deliv);
                    chk("rnd_deq_instr", bus.id_instr, mem_word(exp_deliv));
                    chk("rnd_deq_pc4", bus.id_pc4, exp_deliv + 32'd4);
                    exp_deliv = exp_deliv + 32'd4;
                    accepts++;
                end
            end
`ifdef IF_MISALIGN_TRAP_EN
            if (bus.id_valid) chk("rnd_no_fault", 32'(bus.id_fault), 0);
`endif
            prev_hold  = bus.id_valid & ~bus.id_ready & ~bus.redirect_valid;
            prev_pc    = bus.id_pc;
            prev_instr = bus.id_instr;
        end
        chk("rnd_throughput", 32'(accepts > 300), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
